apb_master_seq: RTL and testbench

- Parametrised APB master sequencer. Successor to the fixed single-write directed driver.
- Accepts read/write commands through a valid/ready port and buffers them in a DEPTH-entry FIFO.
- Issues each command as an APB setup/access transfer, honouring PReady wait states, PSlvErr and a wait-state timeout.
- Returns one response per command. Sits between bench or CPU-side sequencers and the APB slave/memory.

---
 rtl/apb_master_seq_if.sv | 41 ++++
 rtl/apb_master_seq.sv | 165 ++++++++++++++++
 tb/tb_apb_master_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_seq_if.sv
// Bundle of the command, response and APB bus signals around apb_master_seq.
// The master modport is the sequencer's view; the slave modport is the peer side.
interface apb_master_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;

  logic [ADDR_W-1:0] PAddr;
  logic              PWrite;
  logic              PSel;
  logic              PEnable;
  logic [DATA_W-1:0] PWData;
  logic [DATA_W-1:0] PRData;
  logic              PReady;
  logic              PSlvErr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRData, PReady, PSlvErr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    output PAddr, PWrite, PSel, PEnable, PWData
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRData, PReady, PSlvErr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    input  PAddr, PWrite, PSel, PEnable, PWData
  );
endinterface

// File: rtl/apb_master_seq.sv
// APB master sequencer: queues read/write commands in a small FIFO and issues them
// as APB setup/access transfers with wait-state timeout, one response per command.
module apb_master_seq #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              Rst,
  apb_master_seq_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_cmd_ready;
  logic              r_busy;

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic [ENT_W-1:0]  w_entries [DEPTH];
  logic [ENT_W-1:0]  w_head;
  logic              w_head_write;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_to_hit;
  logic w_done;

  assign w_empty  = (r_count == '0);
  // r_cmd_ready already encodes "not full", so a push is refused while full even if a pop happens.
  assign w_push   = bus.cmd_valid & r_cmd_ready;
  assign w_to_hit = (r_state == S_ACCESS) && !bus.PReady && (r_to_cnt == TO_LAST);
  assign w_done   = (r_state == S_ACCESS) && (bus.PReady || w_to_hit);
  assign w_pop    = !w_empty && ((r_state == S_IDLE) || w_done);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ENT_W-1:0] r_entry;
      always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
          r_entry <= '0;
        end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_entry <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
        end
      end
      assign w_entries[gi] = r_entry;
    end
  endgenerate

  assign w_head       = w_entries[r_rd_ptr];
  assign w_head_write = w_head[ENT_W-1];
  assign w_head_addr  = w_head[ENT_W-2 -: ADDR_W];
  assign w_head_data  = w_head[DATA_W-1:0];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_next = S_SETUP;
      S_SETUP:  w_state_next = S_ACCESS;
      S_ACCESS: if (w_done) w_state_next = w_empty ? S_IDLE : S_SETUP;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_to_cnt      <= '0;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_cmd_ready <= (w_count_next != FULL_CNT);
      r_busy      <= (w_count_next != '0) || (w_state_next != S_IDLE);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      if (w_pop) begin
        r_paddr  <= w_head_addr;
        r_pwrite <= w_head_write;
        r_pwdata <= w_head_write ? w_head_data : '0;
      end
      r_psel    <= (w_state_next != S_IDLE);
      r_penable <= (w_state_next == S_ACCESS);

      // Counter saturates at TIMEOUT on abort and only restarts on the next SETUP.
      if (w_state_next == S_SETUP) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !bus.PReady) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      r_rsp_valid   <= w_done;
      r_rsp_rdata   <= (w_done && bus.PReady && !r_pwrite) ? bus.PRData : '0;
      r_rsp_err     <= w_done && (w_to_hit || bus.PSlvErr);
      r_rsp_timeout <= w_to_hit;
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.busy        = r_busy;
  assign bus.PSel        = r_psel;
  assign bus.PEnable     = r_penable;
  assign bus.PWrite      = r_pwrite;
  assign bus.PAddr       = r_paddr;
  assign bus.PWData      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_seq.sv
// Bench for apb_master_seq: directed scenarios plus a randomized stream checked against
// an in-order transaction model and an APB slave memory with scripted wait states/errors.
module tb_apb_master_seq;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct { logic w; logic [15:0] a; logic [31:0] d; } cmd_t;
  typedef struct { logic [31:0] rdata; logic err; logic to; } rsp_t;

  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  apb_master_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  apb_master_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] slv_mem [logic [15:0]];
  logic [31:0] ref_mem [logic [15:0]];
  int   wait_q[$];
  bit   err_q[$];
  cmd_t xfer_q[$];
  cmd_t cmd_log[$];
  rsp_t obs_q[$];
  rsp_t exp_q[$];

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a, ~a};
  endfunction

  // Reference: a transfer with TIMEOUT or more wait states is aborted; otherwise a write
  // updates memory unless the slave errors, and a read returns the current memory word.
  function automatic rsp_t model(input cmd_t c, input int w, input bit e);
    rsp_t r;
    if (w >= TIMEOUT) begin
      r = '{32'h0, 1'b1, 1'b1};
      return r;
    end
    r.to  = 1'b0;
    r.err = e;
    if (c.w) begin
      r.rdata = 32'h0;
      if (!e) ref_mem[c.a] = c.d;
    end else begin
      r.rdata = ref_mem.exists(c.a) ? ref_mem[c.a] : dflt(c.a);
    end
    return r;
  endfunction

  // APB slave: each transfer holds PReady low for its scripted number of ACCESS cycles.
  int cur_w = 0;
  int acc_k = 0;
  bit cur_err = 1'b0;
  always @(negedge clk) begin
    bus.PReady  = 1'b0;
    bus.PSlvErr = 1'b0;
    bus.PRData  = $urandom();
    if (bus.PSel === 1'b1 && bus.PEnable === 1'b0) begin
      cur_w = 0;
      cur_err = 1'b0;
      if (wait_q.size() > 0) cur_w = wait_q.pop_front();
      if (err_q.size() > 0) cur_err = err_q.pop_front();
      acc_k = 0;
      xfer_q.push_back('{bus.PWrite, bus.PAddr, bus.PWData});
    end else if (bus.PSel === 1'b1 && bus.PEnable === 1'b1) begin
      if (acc_k == cur_w) begin
        bus.PReady  = 1'b1;
        bus.PSlvErr = cur_err;
        if (!bus.PWrite) bus.PRData = slv_mem.exists(bus.PAddr) ? slv_mem[bus.PAddr] : dflt(bus.PAddr);
      end
      acc_k++;
    end
  end

  always @(posedge clk) begin
    if (Rst === 1'b0 && bus.PSel === 1'b1 && bus.PEnable === 1'b1 && bus.PReady === 1'b1 &&
        bus.PWrite === 1'b1 && bus.PSlvErr === 1'b0)
      slv_mem[bus.PAddr] = bus.PWData;
  end

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      obs_q.push_back('{bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout});
      $display("rsp #%0d: rdata=%h err=%0b timeout=%0b", obs_q.size(), bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
    end
  end

  task automatic clear_sb();
    obs_q.delete(); exp_q.delete(); xfer_q.delete(); cmd_log.delete();
    wait_q.delete(); err_q.delete();
  endtask

  task automatic plan(input cmd_t c, input int w, input bit e);
    wait_q.push_back(w);
    err_q.push_back(e);
    exp_q.push_back(model(c, w, e));
    cmd_log.push_back(c);
  endtask

  // Offers one command from posedge+1 until accepted; returns at posedge+1 after acceptance.
  task automatic push_cmd(input cmd_t c, output int stalls);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = c.w;
    bus.cmd_addr  = c.a;
    bus.cmd_wdata = c.d;
    stalls = 0;
    while (bus.cmd_ready !== 1'b1 && stalls < 300) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL push_accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, stalls);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", bus.cmd_ready); end
    n_cmp++; if ({bus.PSel, bus.PEnable, bus.PWrite, bus.busy, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got PSel=%b PEnable=%b PWrite=%b busy=%b rsp_valid=%b rsp_err=%b rsp_timeout=%b, required all 0",
                         bus.PSel, bus.PEnable, bus.PWrite, bus.busy, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout);
    end
    n_cmp++; if (bus.PAddr !== 16'h0 || bus.PWData !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got PAddr=%h PWData=%h rsp_rdata=%h, required 0", bus.PAddr, bus.PWData, bus.rsp_rdata);
    end
    @(negedge clk); Rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.PSel !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got PSel=%b busy=%b, required 0 0", bus.PSel, bus.busy);
    end
  endtask

  task automatic test_single_write();
    cmd_t c; int st; bit ok;
    clear_sb();
    c = '{1'b1, 16'h0050, 32'h0000_0050};
    plan(c, 0, 1'b0);
    push_cmd(c, st);
    n_cmp++; if (bus.PSel !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL wr_edgeN: got PSel=%b busy=%b, required 0 1", bus.PSel, bus.busy);
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.PSel !== 1'b1 || bus.PEnable !== 1'b0 || bus.PAddr !== 16'h0050 || bus.PWrite !== 1'b1) begin
      n_fail++; $display("FAIL wr_setup: got PSel=%b PEnable=%b PAddr=%h PWrite=%b, required 1 0 0050 1", bus.PSel, bus.PEnable, bus.PAddr, bus.PWrite);
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.PSel !== 1'b1 || bus.PEnable !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.PWData !== 32'h50) begin
      n_fail++; $display("FAIL wr_access: got PSel=%b PEnable=%b rsp_valid=%b PWData=%h, required 1 1 0 00000050", bus.PSel, bus.PEnable, bus.rsp_valid, bus.PWData);
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.PSel !== 1'b0) begin
      n_fail++; $display("FAIL wr_rsp: got rsp_valid=%b err=%b timeout=%b rdata=%h PSel=%b, required 1 0 0 00000000 0",
                         bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, bus.PSel);
    end
    drain(50, ok);
    n_cmp++; if (!ok || obs_q.size() != 1) begin n_fail++; $display("FAIL wr_count: got %0d responses (idle=%0b), required 1", obs_q.size(), ok); end
    n_cmp++; if (!slv_mem.exists(16'h50) || slv_mem[16'h50] !== 32'h50) begin
      n_fail++; $display("FAIL wr_mem: got mem[0050]=%h, required 00000050", slv_mem.exists(16'h50) ? slv_mem[16'h50] : 32'hx);
    end
  endtask

  task automatic test_read_wait();
    cmd_t c; int st; int en_cnt; bit seen; bit ok; logic [31:0] rd; logic er;
    clear_sb();
    c = '{1'b0, 16'h0050, 32'hDEAD_BEEF};
    plan(c, 3, 1'b0);
    push_cmd(c, st);
    en_cnt = 0; seen = 1'b0; rd = '0; er = 1'bx;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.PEnable === 1'b1) begin
        en_cnt++;
        if (bus.PWData !== 32'h0) begin n_cmp++; n_fail++; $display("FAIL rd_pwdata: got %h, required 00000000", bus.PWData); end
      end
      if (bus.rsp_valid === 1'b1) begin seen = 1'b1; rd = bus.rsp_rdata; er = bus.rsp_err; end
    end
    n_cmp++; if (!seen || en_cnt != 4) begin n_fail++; $display("FAIL rd_penable_cycles: got %0d (rsp seen=%0b), required 4", en_cnt, seen); end
    n_cmp++; if (rd !== 32'h50 || er !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got rdata=%h err=%b, required 00000050 0", rd, er); end
    drain(50, ok);
  endtask

  task automatic test_slave_err();
    cmd_t c; int st; bit ok;
    clear_sb();
    c = '{1'b1, 16'h0060, $urandom()};
    plan(c, 1, 1'b1);
    push_cmd(c, st);
    drain(50, ok);
    n_cmp++; if (!ok || obs_q.size() != 1) begin
      n_fail++; $display("FAIL err_count: got %0d responses, required 1", obs_q.size());
    end else begin
      n_cmp++; if (obs_q[0].err !== 1'b1 || obs_q[0].to !== 1'b0 || obs_q[0].rdata !== 32'h0) begin
        n_fail++; $display("FAIL err_rsp: got err=%b timeout=%b rdata=%h, required 1 0 00000000", obs_q[0].err, obs_q[0].to, obs_q[0].rdata);
      end
    end
  endtask

  task automatic test_timeout();
    cmd_t c0, c1; int st; int en_cnt; bit seen; bit ok;
    clear_sb();
    c0 = '{1'b0, 16'h0070, 32'h0};
    c1 = '{1'b1, 16'h0074, $urandom()};
    plan(c0, 100, 1'b0);
    plan(c1, 0, 1'b0);
    push_cmd(c0, st);
    push_cmd(c1, st);
    en_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.PEnable === 1'b1) en_cnt++;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_cmp++; if (!seen || en_cnt != TIMEOUT) begin n_fail++; $display("FAIL to_penable_cycles: got %0d (rsp seen=%0b), required %0d", en_cnt, seen, TIMEOUT); end
    n_cmp++; if (bus.rsp_err !== 1'b1 || bus.rsp_timeout !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL to_rsp: got err=%b timeout=%b rdata=%h, required 1 1 00000000", bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata);
    end
    drain(100, ok);
    n_cmp++; if (!ok || obs_q.size() != 2) begin
      n_fail++; $display("FAIL to_count: got %0d responses, required 2", obs_q.size());
    end else begin
      n_cmp++; if (obs_q[1].err !== 1'b0 || obs_q[1].to !== 1'b0) begin
        n_fail++; $display("FAIL to_next_rsp: got err=%b timeout=%b, required 0 0", obs_q[1].err, obs_q[1].to);
      end
    end
    n_cmp++; if (!slv_mem.exists(16'h74) || slv_mem[16'h74] !== c1.d) begin
      n_fail++; $display("FAIL to_next_mem: got mem[0074]=%h, required %h", slv_mem.exists(16'h74) ? slv_mem[16'h74] : 32'hx, c1.d);
    end
  endtask

  task automatic test_back_to_back();
    cmd_t c; int st[6]; int gaps; bit ok; logic ready_after_fill;
    clear_sb();
    for (int i = 0; i < 6; i++) begin
      c = '{1'(i % 2 == 0), 16'h0100 + 16'(4 * (i / 2)), $urandom()};
      plan(c, (i == 0) ? 12 : 0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      push_cmd(cmd_log[i], st[i]);
      if (i == 4) ready_after_fill = bus.cmd_ready;
    end
    n_cmp++; if (ready_after_fill !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got cmd_ready=%b with FIFO full, required 0", ready_after_fill); end
    n_cmp++; if (st[0] + st[1] + st[2] + st[3] + st[4] != 0 || st[5] == 0) begin
      n_fail++; $display("FAIL b2b_stalls: got stalls %0d %0d %0d %0d %0d %0d, required 0 x5 then >0", st[0], st[1], st[2], st[3], st[4], st[5]);
    end
    gaps = 0;
    for (int i = 0; i < 200 && bus.busy === 1'b1; i++) begin
      if (bus.PSel !== 1'b1) gaps++;
      @(posedge clk); #1;
    end
    n_cmp++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_psel_gap: got %0d busy cycles with PSel=0, required 0", gaps); end
    drain(50, ok);
    n_cmp++; if (!ok || obs_q.size() != exp_q.size() || xfer_q.size() != cmd_log.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d rsp / %0d xfers, required %0d / %0d", obs_q.size(), xfer_q.size(), exp_q.size(), cmd_log.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].to !== exp_q[i].to) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b to=%b, required rdata=%h err=%b to=%b",
                           i, obs_q[i].rdata, obs_q[i].err, obs_q[i].to, exp_q[i].rdata, exp_q[i].err, exp_q[i].to);
      end
    end
  endtask

  task automatic test_random();
    cmd_t c; int st; int w; int sel; bit e; bit ok; logic [31:0] exp_wd;
    clear_sb();
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       w = $urandom_range(0, 3);
      else if (sel == 7) w = TIMEOUT - 1;
      else if (sel == 8) w = TIMEOUT;
      else               w = TIMEOUT + 3;
      e = ($urandom_range(0, 5) == 0);
      c = '{1'($urandom_range(0, 1)), 16'h0200 + 16'(4 * $urandom_range(0, 7)), $urandom()};
      plan(c, w, e);
      push_cmd(c, st);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain(3000, ok);
    n_cmp++; if (!ok || obs_q.size() != exp_q.size() || xfer_q.size() != cmd_log.size()) begin
      n_fail++; $display("FAIL rnd_count: got %0d rsp / %0d xfers, required %0d / %0d", obs_q.size(), xfer_q.size(), exp_q.size(), cmd_log.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].to !== exp_q[i].to) begin
        n_fail++; $display("FAIL rnd_rsp[%0d]: got rdata=%h err=%b to=%b, required rdata=%h err=%b to=%b",
                           i, obs_q[i].rdata, obs_q[i].err, obs_q[i].to, exp_q[i].rdata, exp_q[i].err, exp_q[i].to);
      end
    end
    for (int i = 0; i < cmd_log.size() && i < xfer_q.size(); i++) begin
      exp_wd = cmd_log[i].w ? cmd_log[i].d : 32'h0;
      n_cmp++; if (xfer_q[i].w !== cmd_log[i].w || xfer_q[i].a !== cmd_log[i].a || xfer_q[i].d !== exp_wd) begin
        n_fail++; $display("FAIL rnd_xfer[%0d]: got w=%b a=%h d=%h, required w=%b a=%h d=%h",
                           i, xfer_q[i].w, xfer_q[i].a, xfer_q[i].d, cmd_log[i].w, cmd_log[i].a, exp_wd);
      end
    end
  endtask

  task automatic test_reset_mid();
    cmd_t c; int st; int psel_cnt; int rv_cnt;
    clear_sb();
    for (int i = 0; i < 3; i++) begin
      c = '{1'b0, 16'h0300 + 16'(4 * i), 32'h0};
      plan(c, (i == 0) ? 100 : 0, 1'b0);
    end
    for (int i = 0; i < 3; i++) push_cmd(cmd_log[i], st);
    for (int i = 0; i < 10 && bus.PEnable !== 1'b1; i++) begin @(posedge clk); #1; end
    n_cmp++; if (bus.PEnable !== 1'b1) begin n_fail++; $display("FAIL rst_mid_access: got PEnable=%b before reset, required 1", bus.PEnable); end
    @(posedge clk); #2;
    Rst = 1'b1;
    #1;
    n_cmp++; if (bus.PSel !== 1'b0 || bus.PEnable !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: got PSel=%b PEnable=%b busy=%b cmd_ready=%b rsp_valid=%b, required 0 0 0 1 0",
                         bus.PSel, bus.PEnable, bus.busy, bus.cmd_ready, bus.rsp_valid);
    end
    @(negedge clk); Rst = 1'b0;
    wait_q.delete(); err_q.delete();
    psel_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.PSel !== 1'b0) psel_cnt++;
      if (bus.rsp_valid !== 1'b0) rv_cnt++;
    end
    n_cmp++; if (psel_cnt != 0 || rv_cnt != 0 || obs_q.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got PSel cycles=%0d rsp_valid cycles=%0d responses=%0d busy=%b, required 0 0 0 0",
                         psel_cnt, rv_cnt, obs_q.size(), bus.busy);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_slave_err();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
